// File: rtl/activity_zone_tracker.sv
`default_nettype none
// ============================================================================
// Module   : activity_zone_tracker
// Brief    : Per-zone qualified high-activity timer. Each second compares the
//            pulse rate against NUM_ZONES thresholds and accumulates credited
//            run time per zone. Optional macro: ZONE_LONGEST_RUN_EN adds
//            per-zone longest-run tracking on the longest_run port.
// Revision : 1.0  initial release
// ============================================================================
module activity_zone_tracker #(
    parameter int NUM_ZONES = 3,
    parameter int RATE_W    = 10,
    parameter int TIME_W    = 16,
    parameter int QUAL_SECS = 60
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          sec_tick,
    input  logic                          en,
    input  logic                          clr,
    input  logic [RATE_W-1:0]             ppm,
    input  logic [NUM_ZONES*RATE_W-1:0]   thr,
    output logic [NUM_ZONES*TIME_W-1:0]   zone_time,
    output logic [NUM_ZONES-1:0]          zone_active,
    output logic [NUM_ZONES-1:0]          zone_sat
`ifdef ZONE_LONGEST_RUN_EN
    ,
    output logic [NUM_ZONES*TIME_W-1:0]   longest_run
`endif
);

    localparam int                QCNT_W    = $clog2(QUAL_SECS);
    localparam logic [QCNT_W-1:0] QCNT_LAST = QCNT_W'(QUAL_SECS - 1);
    localparam logic [TIME_W:0]   QUAL_EXT  = (TIME_W+1)'(QUAL_SECS);
    localparam logic [TIME_W-1:0] TIME_MAX  = {TIME_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_QUAL   = 2'd1,
        ST_ACTIVE = 2'd2
    } zone_state_t;

    logic sample;
    assign sample = sec_tick & en & ~clr;

    for (genvar k = 0; k < NUM_ZONES; k++) begin : g_zone
        zone_state_t       state_q, state_d;
        logic [QCNT_W-1:0] qcnt_q, qcnt_d;
        logic [TIME_W-1:0] time_q, time_d;
        logic              sat_q, sat_d;
        logic              qualify;
        logic [TIME_W:0]   add_amt;
        logic [TIME_W:0]   sum;
`ifdef ZONE_LONGEST_RUN_EN
        logic [TIME_W-1:0] run_q, run_d;
        logic [TIME_W-1:0] long_q, long_d;
`endif

        assign qualify = (ppm >= thr[k*RATE_W +: RATE_W]);

        always_comb begin
            state_d = state_q;
            qcnt_d  = qcnt_q;
            time_d  = time_q;
            sat_d   = sat_q;
            add_amt = '0;
            sum     = '0;
`ifdef ZONE_LONGEST_RUN_EN
            run_d   = run_q;
            long_d  = long_q;
`endif
            if (clr) begin
                state_d = ST_IDLE;
                qcnt_d  = '0;
                time_d  = '0;
                sat_d   = 1'b0;
`ifdef ZONE_LONGEST_RUN_EN
                run_d   = '0;
                long_d  = '0;
`endif
            end else if (sample) begin
                case (state_q)
                    ST_IDLE: begin
                        if (qualify) begin
                            state_d = ST_QUAL;
                            qcnt_d  = QCNT_W'(1);
                        end
                    end
                    ST_QUAL: begin
                        if (!qualify) begin
                            state_d = ST_IDLE;
                            qcnt_d  = '0;
                        end else if (qcnt_q == QCNT_LAST) begin
                            state_d = ST_ACTIVE;
                            qcnt_d  = '0;
                            add_amt = QUAL_EXT;
`ifdef ZONE_LONGEST_RUN_EN
                            run_d   = TIME_W'(QUAL_SECS);
`endif
                        end else begin
                            qcnt_d = qcnt_q + QCNT_W'(1);
                        end
                    end
                    ST_ACTIVE: begin
                        if (qualify) begin
                            add_amt = (TIME_W+1)'(1);
`ifdef ZONE_LONGEST_RUN_EN
                            run_d   = (run_q == TIME_MAX) ? TIME_MAX : run_q + TIME_W'(1);
`endif
                        end else begin
                            state_d = ST_IDLE;
`ifdef ZONE_LONGEST_RUN_EN
                            run_d   = '0;
`endif
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                        qcnt_d  = '0;
                    end
                endcase

                // Widen by one bit so an overflowing add clamps instead of wrapping.
                if (add_amt != '0) begin
                    sum = {1'b0, time_q} + add_amt;
                    if (sum > {1'b0, TIME_MAX}) begin
                        time_d = TIME_MAX;
                    end else begin
                        time_d = sum[TIME_W-1:0];
                    end
                    if (time_d == TIME_MAX) begin
                        sat_d = 1'b1;
                    end
                end
`ifdef ZONE_LONGEST_RUN_EN
                if (run_d > long_q) begin
                    long_d = run_d;
                end
`endif
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state_q <= ST_IDLE;
                qcnt_q  <= '0;
                time_q  <= '0;
                sat_q   <= 1'b0;
`ifdef ZONE_LONGEST_RUN_EN
                run_q   <= '0;
                long_q  <= '0;
`endif
            end else begin
                state_q <= state_d;
                qcnt_q  <= qcnt_d;
                time_q  <= time_d;
                sat_q   <= sat_d;
`ifdef ZONE_LONGEST_RUN_EN
                run_q   <= run_d;
                long_q  <= long_d;
`endif
            end
        end

        assign zone_time[k*TIME_W +: TIME_W] = time_q;
        assign zone_active[k]                = (state_q == ST_ACTIVE);
        assign zone_sat[k]                   = sat_q;
`ifdef ZONE_LONGEST_RUN_EN
        assign longest_run[k*TIME_W +: TIME_W] = long_q;
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_activity_zone_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_activity_zone_tracker
// Brief    : Self-checking bench for activity_zone_tracker (3 zones, 4 s
//            qualification, 8-bit counters, thresholds 90/120/150).
// Revision : 1.0  initial release
// ============================================================================
module tb_activity_zone_tracker;

    localparam int NZ = 3;
    localparam int RW = 10;
    localparam int TW = 8;
    localparam int QS = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              sec_tick;
    logic              en;
    logic              clr;
    logic [RW-1:0]     ppm;
    logic [NZ*RW-1:0]  thr;
    logic [NZ*TW-1:0]  zone_time;
    logic [NZ-1:0]     zone_active;
    logic [NZ-1:0]     zone_sat;
`ifdef ZONE_LONGEST_RUN_EN
    logic [NZ*TW-1:0]  longest_run;
`endif

    activity_zone_tracker #(
        .NUM_ZONES (NZ),
        .RATE_W    (RW),
        .TIME_W    (TW),
        .QUAL_SECS (QS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sec_tick    (sec_tick),
        .en          (en),
        .clr         (clr),
        .ppm         (ppm),
        .thr         (thr),
        .zone_time   (zone_time),
        .zone_active (zone_active),
        .zone_sat    (zone_sat)
`ifdef ZONE_LONGEST_RUN_EN
        ,
        .longest_run (longest_run)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        clr;
        logic        en;
        logic        tick;
        logic [9:0]  ppm;
        logic [23:0] t;
        logic [2:0]  act;
        logic [2:0]  sat;
    } vec_t;

    typedef struct {
        logic [23:0] t;
        logic [2:0]  act;
        logic [2:0]  sat;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        n_cmp++;
        if (got !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, got, req);
        end
    endtask

    function automatic void addv(input logic c, input logic e, input logic tk, input logic [9:0] p,
                                 input logic [23:0] t, input logic [2:0] a, input logic [2:0] s);
        vec_t v;
        v.clr = c; v.en = e; v.tick = tk; v.ppm = p; v.t = t; v.act = a; v.sat = s;
        vecs.push_back(v);
    endfunction

    // Drive one cycle at a falling edge, queue its expectation, compare one cycle later.
    task automatic step(input logic c, input logic e, input logic tk, input logic [9:0] p,
                        input logic [23:0] et, input logic [2:0] ea, input logic [2:0] es,
                        input string nm);
        exp_t x;
        clr = c; en = e; sec_tick = tk; ppm = p;
        x.t = et; x.act = ea; x.sat = es;
        sb_q.push_back(x);
        @(negedge clk);
        x = sb_q.pop_front();
        check({nm, ".time"},   {8'h0, zone_time},    {8'h0, x.t});
        check({nm, ".active"}, {29'h0, zone_active}, {29'h0, x.act});
        check({nm, ".sat"},    {29'h0, zone_sat},    {29'h0, x.sat});
        sec_tick = 1'b0;
        clr      = 1'b0;
    endtask

    initial begin
        int et;
        reset    = 1'b0;
        sec_tick = 1'b0;
        en       = 1'b1;
        clr      = 1'b0;
        ppm      = '0;
        thr      = {10'd150, 10'd120, 10'd90};
        repeat (2) @(negedge clk);
        check("reset.time",   {8'h0, zone_time},    32'h0);
        check("reset.active", {29'h0, zone_active}, 32'h0);
        check("reset.sat",    {29'h0, zone_sat},    32'h0);
        reset = 1'b1;
        @(negedge clk);

        // Zone0-only run, credited on the 4th tick, dropped at ppm 80
        addv(0,1,1,100, 24'h000000, 3'b000, 3'b000);
        addv(0,1,1,100, 24'h000000, 3'b000, 3'b000);
        addv(0,1,1,100, 24'h000000, 3'b000, 3'b000);
        addv(0,1,1,100, 24'h000004, 3'b001, 3'b000);
        addv(0,1,1,100, 24'h000005, 3'b001, 3'b000);
        addv(0,1,1,100, 24'h000006, 3'b001, 3'b000);
        addv(0,1,1, 80, 24'h000006, 3'b000, 3'b000);
        addv(1,1,0,  0, 24'h000000, 3'b000, 3'b000);
        // Partial run is never credited
        addv(0,1,1,130, 24'h000000, 3'b000, 3'b000);
        addv(0,1,1,130, 24'h000000, 3'b000, 3'b000);
        addv(0,1,1,130, 24'h000000, 3'b000, 3'b000);
        addv(0,1,1, 80, 24'h000000, 3'b000, 3'b000);
        addv(1,1,0,  0, 24'h000000, 3'b000, 3'b000);
        // All zones, with an en=0 gap while ACTIVE
        addv(0,1,1,160, 24'h000000, 3'b000, 3'b000);
        addv(0,1,1,160, 24'h000000, 3'b000, 3'b000);
        addv(0,1,1,160, 24'h000000, 3'b000, 3'b000);
        addv(0,1,1,160, 24'h040404, 3'b111, 3'b000);
        addv(0,1,1,160, 24'h050505, 3'b111, 3'b000);
        for (int i = 0; i < 10; i++) addv(0,0,1,0, 24'h050505, 3'b111, 3'b000);
        addv(0,1,1,160, 24'h060606, 3'b111, 3'b000);
        addv(0,1,1,160, 24'h070707, 3'b111, 3'b000);
        addv(1,1,0,  0, 24'h000000, 3'b000, 3'b000);
        // ppm equal to threshold qualifies; one below drops
        addv(0,1,1, 90, 24'h000000, 3'b000, 3'b000);
        addv(0,1,1, 90, 24'h000000, 3'b000, 3'b000);
        addv(0,1,1, 90, 24'h000000, 3'b000, 3'b000);
        addv(0,1,1, 90, 24'h000004, 3'b001, 3'b000);
        addv(0,1,1, 89, 24'h000004, 3'b000, 3'b000);
        addv(1,1,0,  0, 24'h000000, 3'b000, 3'b000);
        // en gap during qualification freezes the count
        addv(0,1,1,100, 24'h000000, 3'b000, 3'b000);
        addv(0,1,1,100, 24'h000000, 3'b000, 3'b000);
        addv(0,0,1,  0, 24'h000000, 3'b000, 3'b000);
        addv(0,0,1,  0, 24'h000000, 3'b000, 3'b000);
        addv(0,1,1,100, 24'h000000, 3'b000, 3'b000);
        addv(0,1,1,100, 24'h000004, 3'b001, 3'b000);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].clr, vecs[i].en, vecs[i].tick, vecs[i].ppm,
                 vecs[i].t, vecs[i].act, vecs[i].sat, $sformatf("vec%0d", i));
        end

        // Saturation of zone0 at 255
        step(1,1,0,0, 24'h0, 3'b000, 3'b000, "sat_clr");
        for (int n = 1; n <= 260; n++) begin
            et = (n < QS) ? 0 : ((n > 255) ? 255 : n);
            step(0,1,1,100, 24'(et), (n >= QS) ? 3'b001 : 3'b000,
                 (n >= 255) ? 3'b001 : 3'b000, $sformatf("sat%0d", n));
        end

        // Asynchronous reset between ticks while ACTIVE
        step(1,1,0,0, 24'h0, 3'b000, 3'b000, "rst_clr");
        for (int n = 1; n <= 5; n++) begin
            step(0,1,1,100, (n < QS) ? 24'h0 : 24'(n), (n >= QS) ? 3'b001 : 3'b000,
                 3'b000, $sformatf("rst_run%0d", n));
        end
        #2 reset = 1'b0;
        #1;
        check("async_rst.time",   {8'h0, zone_time},    32'h0);
        check("async_rst.active", {29'h0, zone_active}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        step(0,1,1,100, 24'h0, 3'b000, 3'b000, "post_rst");

        // clr coinciding with a tick wins, and the tick is not counted
        step(1,1,0,0, 24'h0, 3'b000, 3'b000, "ct_clr");
        for (int n = 1; n <= 4; n++) begin
            step(0,1,1,100, (n < QS) ? 24'h0 : 24'(n), (n >= QS) ? 3'b001 : 3'b000,
                 3'b000, $sformatf("ct_run%0d", n));
        end
        step(1,1,1,100, 24'h0, 3'b000, 3'b000, "clr_tick");
        step(0,1,1,100, 24'h0, 3'b000, 3'b000, "ct_after1");
        step(0,1,1,100, 24'h0, 3'b000, 3'b000, "ct_after2");
        step(0,1,1,100, 24'h0, 3'b000, 3'b000, "ct_after3");
        step(0,1,1,100, 24'h000004, 3'b001, 3'b000, "ct_after4");

`ifdef ZONE_LONGEST_RUN_EN
        step(1,1,0,0, 24'h0, 3'b000, 3'b000, "lr_clr");
        check("lr_cleared", {8'h0, longest_run}, 32'h0);
        for (int n = 1; n <= 6; n++) begin
            step(0,1,1,100, (n < QS) ? 24'h0 : 24'(n), (n >= QS) ? 3'b001 : 3'b000,
                 3'b000, $sformatf("lr_a%0d", n));
        end
        step(0,1,1,80, 24'h000006, 3'b000, 3'b000, "lr_drop");
        for (int n = 1; n <= 5; n++) begin
            step(0,1,1,100, (n < QS) ? 24'h6 : 24'(6 + n), (n >= QS) ? 3'b001 : 3'b000,
                 3'b000, $sformatf("lr_b%0d", n));
        end
        check("longest_run", {8'h0, longest_run}, 32'h000006);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
